// File: rtl/tick_divider_bank.sv
// Bank of independent programmable clock-enable dividers, all clocked by iCLK_50.
// Each channel produces a one-cycle tick every div+1 cycles, a toggling square wave and a wrapping event count.
module tick_divider_bank #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DIV_W       = 27,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 67108863
) (
    input  logic                      iCLK_50,
    input  logic                      iRST_n,
    input  logic                      iWR,
    input  logic [3:0]                iWR_CH,
    input  logic [DIV_W-1:0]          iWR_DIV,
    input  logic [NUM_CH-1:0]         iEN,
    input  logic [NUM_CH-1:0]         iCLR_CNT,
    output logic [NUM_CH-1:0]         oTICK,
    output logic [NUM_CH-1:0]         oSQ,
    output logic [NUM_CH*CNT_W-1:0]   oCNT
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] pc_q;
        logic             tick_q;
        logic             sq_q;
        logic [CNT_W-1:0] cnt_q;
        logic             wr_hit;
        logic             at_end;
        logic             fire;

        assign wr_hit = iWR && (iWR_CH == 4'(k));
        assign at_end = (pc_q == div_q);
        // A write outranks the tick, so a tick is only taken on an enabled, non-written edge.
        assign fire   = !wr_hit && iEN[k] && at_end;

        always_ff @(posedge iCLK_50 or negedge iRST_n) begin
            if (!iRST_n) begin
                div_q  <= RESET_DIV;
                pc_q   <= '0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else if (wr_hit) begin
                div_q  <= iWR_DIV;
                pc_q   <= '0;
                tick_q <= 1'b0;
            end else if (!iEN[k]) begin
                pc_q   <= '0;
                tick_q <= 1'b0;
            end else if (at_end) begin
                pc_q   <= '0;
                tick_q <= 1'b1;
                sq_q   <= ~sq_q;
            end else begin
                pc_q   <= pc_q + DIV_W'(1);
                tick_q <= 1'b0;
            end
        end

        // Clear wins over a coincident tick increment.
        always_ff @(posedge iCLK_50 or negedge iRST_n) begin
            if (!iRST_n) begin
                cnt_q <= '0;
            end else if (iCLR_CNT[k]) begin
                cnt_q <= '0;
            end else if (fire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign oTICK[k]                 = tick_q;
        assign oSQ[k]                   = sq_q;
        assign oCNT[k*CNT_W +: CNT_W]   = cnt_q;
    end

endmodule
